collision_event_handler: RTL

- Consumes the per-frame collision flags (player/sword/sheep vs dragon) produced by the collision detection unit.
- Samples them once per frame at the frame boundary and turns them into single-cycle game events: player hit, dragon hurt, dragon grow, sheep respawn.
- Owns the player lives count, the invincibility window and the game-over state.
- Sits between the collision detector and the dragon/sheep/player controllers.

---
 rtl/collision_event_handler_if.sv | 33 +++
 rtl/collision_event_handler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/collision_event_handler_if.sv
// Collision flag / game event bundle between the collision detector, the
// collision_event_handler and the dragon/sheep/player controllers.
interface collision_event_handler_if #(
    parameter int SCORE_WIDTH = 8
);
    logic                   frameEnd;
    logic                   restart;
    logic                   playerDragonCollision;
    logic                   swordDragonCollision;
    logic                   sheepDragonCollision;
    logic [2:0]             lives;
    logic                   invincible;
    logic                   gameOver;
    logic                   playerHit;
    logic                   dragonHurt;
    logic                   dragonGrow;
    logic                   sheepRespawn;
    logic [SCORE_WIDTH-1:0] score;

    modport master (
        output frameEnd, restart,
        output playerDragonCollision, swordDragonCollision, sheepDragonCollision,
        input  lives, invincible, gameOver,
        input  playerHit, dragonHurt, dragonGrow, sheepRespawn, score
    );

    modport slave (
        input  frameEnd, restart,
        input  playerDragonCollision, swordDragonCollision, sheepDragonCollision,
        output lives, invincible, gameOver,
        output playerHit, dragonHurt, dragonGrow, sheepRespawn, score
    );
endinterface

// File: rtl/collision_event_handler.sv
// Turns per-frame collision flags into one-cycle game events and owns lives,
// invincibility and game-over. Optional score counter: define COLLISION_SCORE_EN.
module collision_event_handler #(
    parameter int START_LIVES       = 3,
    parameter int INVINCIBLE_FRAMES = 60,
    parameter int SCORE_WIDTH       = 8
) (
    input logic                     clk,
    input logic                     reset,
    collision_event_handler_if.slave bus
);
    typedef enum logic [1:0] {PLAY, INVULN, GAME_OVER} state_t;

    localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
    localparam logic [7:0] INV_INIT   = 8'(INVINCIBLE_FRAMES);

    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] inv_q, inv_d;
    logic       hit_q, hit_d;
    logic       hurt_q, hurt_d;
    logic       grow_q, grow_d;
    logic       resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        inv_d   = inv_q;
        hit_d   = 1'b0;
        hurt_d  = 1'b0;
        grow_d  = 1'b0;
        resp_d  = 1'b0;
        case (state_q)
            PLAY: begin
                if (bus.frameEnd) begin
                    if (bus.playerDragonCollision) begin
                        hit_d = 1'b1;
                        if (lives_q > 3'd1) begin
                            lives_d = lives_q - 3'd1;
                            inv_d   = INV_INIT;
                            state_d = INVULN;
                        end else begin
                            lives_d = 3'd0;
                            state_d = GAME_OVER;
                        end
                    end
                    // A fatal hit ends the frame: no dragon/sheep events alongside it.
                    if (state_d != GAME_OVER) begin
                        hurt_d = bus.swordDragonCollision;
                        grow_d = bus.sheepDragonCollision;
                        resp_d = bus.sheepDragonCollision;
                    end
                end
            end
            INVULN: begin
                if (bus.frameEnd) begin
                    // Window counts down to zero, then one more frame before leaving.
                    if (inv_q == 8'd0) begin
                        state_d = PLAY;
                    end else begin
                        inv_d = inv_q - 8'd1;
                    end
                    hurt_d = bus.swordDragonCollision;
                    grow_d = bus.sheepDragonCollision;
                    resp_d = bus.sheepDragonCollision;
                end
            end
            GAME_OVER: begin
                if (bus.restart) begin
                    lives_d = LIVES_INIT;
                    state_d = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PLAY;
            lives_q <= LIVES_INIT;
            inv_q   <= 8'd0;
            hit_q   <= 1'b0;
            hurt_q  <= 1'b0;
            grow_q  <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            inv_q   <= inv_d;
            hit_q   <= hit_d;
            hurt_q  <= hurt_d;
            grow_q  <= grow_d;
            resp_q  <= resp_d;
        end
    end

`ifdef COLLISION_SCORE_EN
    logic [SCORE_WIDTH-1:0] score_q, score_d;

    function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] s);
        return (&s) ? s : s + 1'b1;
    endfunction

    always_comb begin
        score_d = score_q;
        if (hurt_d) begin
            score_d = sat_inc(score_q);
        end
        if (state_q == GAME_OVER && bus.restart) begin
            score_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = {SCORE_WIDTH{1'b0}};
`endif

    assign bus.lives        = lives_q;
    assign bus.invincible   = (state_q == INVULN);
    assign bus.gameOver     = (state_q == GAME_OVER);
    assign bus.playerHit    = hit_q;
    assign bus.dragonHurt   = hurt_q;
    assign bus.dragonGrow   = grow_q;
    assign bus.sheepRespawn = resp_q;
endmodule
